// File: rtl/clk_tick_timer.sv
// clk_tick_timer: turns a sampled divided-clock level into tick enables
// and drives a one-shot/periodic countdown of div_clk rising edges.
module clk_tick_timer #(
    parameter int COUNT_WIDTH = 16
) (
    input  logic                   clk_in,
    input  logic                   rst,
    input  logic                   div_clk,
    input  logic                   start,
    input  logic                   periodic,
    input  logic [COUNT_WIDTH-1:0] load_value,
    output logic                   tick,
    output logic                   expire,
    output logic                   busy,
    output logic [COUNT_WIDTH-1:0] remaining
);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    localparam logic [COUNT_WIDTH-1:0] ONE = COUNT_WIDTH'(1);

    state_t                 state_q;
    state_t                 state_d;
    logic                   div_q;
    logic                   rise;
    logic                   start_ok;
    logic                   abort;
    logic                   count;
    logic                   expire_d;
    logic                   per_reg;
    logic                   per_d;
    logic [COUNT_WIDTH-1:0] load_reg;
    logic [COUNT_WIDTH-1:0] load_d;
    logic [COUNT_WIDTH-1:0] rem_d;

    assign rise     = div_clk & ~div_q;
    assign start_ok = start & (load_value != '0);
    assign abort    = start & ~start_ok;
    // a start in the same cycle as an edge wins; that edge is not counted
    assign count    = ~start & rise;
    assign busy     = (state_q == RUN);

    always_comb begin
        state_d  = state_q;
        rem_d    = remaining;
        load_d   = load_reg;
        per_d    = per_reg;
        expire_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start_ok) begin
                    rem_d   = load_value;
                    load_d  = load_value;
                    per_d   = periodic;
                    state_d = RUN;
                end
            end
            RUN: begin
                unique case (1'b1)
                    start_ok: begin
                        rem_d  = load_value;
                        load_d = load_value;
                        per_d  = periodic;
                    end
                    abort: begin
                        rem_d   = '0;
                        state_d = IDLE;
                    end
                    count: begin
                        if (remaining > ONE) begin
                            rem_d = remaining - ONE;
                        end else begin
                            expire_d = 1'b1;
                            if (per_reg) begin
                                rem_d = load_reg;
                            end else begin
                                rem_d   = '0;
                                state_d = IDLE;
                            end
                        end
                    end
                    default: ;
                endcase
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst) begin
            state_q   <= IDLE;
            div_q     <= 1'b1;
            tick      <= 1'b0;
            expire    <= 1'b0;
            remaining <= '0;
            load_reg  <= '0;
            per_reg   <= 1'b0;
        end else begin
            state_q   <= state_d;
            div_q     <= div_clk;
            tick      <= rise;
            expire    <= expire_d;
            remaining <= rem_d;
            load_reg  <= load_d;
            per_reg   <= per_d;
        end
    end

endmodule

// File: tb/tb_clk_tick_timer.sv
// tb_clk_tick_timer: scoreboard bench; a reference model queues the
// expected outputs per driven cycle, a monitor pops them after each edge.
module tb_clk_tick_timer;

    localparam int W = 16;

    typedef struct packed {
        logic         tick;
        logic         expire;
        logic         busy;
        logic [W-1:0] rem;
    } exp_t;

    logic         clk_in = 1'b0;
    logic         rst = 1'b1;
    logic         div_clk = 1'b1;
    logic         start = 1'b0;
    logic         periodic = 1'b0;
    logic [W-1:0] load_value = '0;
    logic         tick;
    logic         expire;
    logic         busy;
    logic [W-1:0] remaining;

    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;
    int   n_tick = 0;
    int   n_exp = 0;
    int   base_t;
    int   base_e;

    logic         m_divq;
    logic         m_run;
    logic [W-1:0] m_rem;
    logic [W-1:0] m_load;
    logic         m_per;
    logic [7:0]   dcnt = '0;

    clk_tick_timer #(.COUNT_WIDTH(W)) dut (
        .clk_in    (clk_in),
        .rst       (rst),
        .div_clk   (div_clk),
        .start     (start),
        .periodic  (periodic),
        .load_value(load_value),
        .tick      (tick),
        .expire    (expire),
        .busy      (busy),
        .remaining (remaining)
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string tag, input int got, input int want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, want);
        end
    endtask

    task automatic step(input logic r, input logic d, input logic s,
                        input logic p, input logic [W-1:0] lv);
        exp_t e;
        logic rise;
        @(negedge clk_in);
        rst = r;
        div_clk = d;
        start = s;
        periodic = p;
        load_value = lv;
        e = '0;
        if (r) begin
            m_divq = 1'b1;
            m_run  = 1'b0;
            m_rem  = '0;
            m_load = '0;
            m_per  = 1'b0;
        end else begin
            rise   = d & ~m_divq;
            m_divq = d;
            e.tick = rise;
            if (s && lv != 0) begin
                m_rem  = lv;
                m_load = lv;
                m_per  = p;
                m_run  = 1'b1;
            end else if (s) begin
                if (m_run) begin
                    m_rem = '0;
                    m_run = 1'b0;
                end
            end else if (m_run && rise) begin
                if (m_rem == 1) begin
                    e.expire = 1'b1;
                    if (m_per) begin
                        m_rem = m_load;
                    end else begin
                        m_rem = '0;
                        m_run = 1'b0;
                    end
                end else begin
                    m_rem = m_rem - 1'b1;
                end
            end
        end
        e.busy = m_run;
        e.rem  = m_rem;
        sb.push_back(e);
    endtask

    task automatic cyc(input logic s, input logic p, input logic [W-1:0] lv);
        dcnt = dcnt + 8'd1;
        step(1'b0, dcnt[7], s, p, lv);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, '0);
    endtask

    task automatic settle();
        @(posedge clk_in);
        #2;
    endtask

    always @(posedge clk_in) begin
        exp_t e;
        #1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("tick", 32'(tick), 32'(e.tick));
            chk("expire", 32'(expire), 32'(e.expire));
            chk("busy", 32'(busy), 32'(e.busy));
            chk("remaining", 32'(remaining), 32'(e.rem));
        end
        if (tick === 1'b1) n_tick++;
        if (expire === 1'b1) n_exp++;
    end

    initial begin
        // 1: reset with div_clk high, no spurious tick
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 1'b0, '0);
        settle();
        chk("rst_busy", 32'(busy), 0);
        chk("rst_rem", 32'(remaining), 0);
        base_t = n_tick;
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0, 1'b0, '0);
        step(1'b0, 1'b0, 1'b0, 1'b0, '0);
        step(1'b0, 1'b1, 1'b0, 1'b0, '0);
        settle();
        chk("t1_tick_hi", 32'(tick), 1);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 1'b0, '0);
        settle();
        chk("t1_tick_cnt", n_tick - base_t, 1);

        // toggling every cycle: one tick per rise
        base_t = n_tick;
        for (int i = 0; i < 10; i++) step(1'b0, 1'(i % 2), 1'b0, 1'b0, '0);
        settle();
        chk("fast_tick_cnt", n_tick - base_t, 5);

        // 2: one-shot of 3 edges with a 256-cycle divider
        dcnt = 8'd0;
        run(40);
        base_e = n_exp;
        cyc(1'b1, 1'b0, 16'd3);
        settle();
        chk("t2_busy", 32'(busy), 1);
        chk("t2_rem", 32'(remaining), 3);
        run(3 * 256);
        settle();
        chk("t2_exp_cnt", n_exp - base_e, 1);
        chk("t2_busy_end", 32'(busy), 0);
        chk("t2_rem_end", 32'(remaining), 0);
        run(512);
        chk("t2_no_more", n_exp - base_e, 1);

        // 3: periodic reload of 2, eight edges -> four expiries
        base_e = n_exp;
        cyc(1'b1, 1'b1, 16'd2);
        run(8 * 256);
        settle();
        chk("t3_exp_cnt", n_exp - base_e, 4);
        chk("t3_busy", 32'(busy), 1);

        // 4: restart coinciding with an edge, then abort
        cyc(1'b1, 1'b0, 16'd5);
        while (dcnt != 8'd127) cyc(1'b0, 1'b0, '0);
        settle();
        chk("t4_rem5", 32'(remaining), 5);
        base_e = n_exp;
        cyc(1'b1, 1'b0, 16'd4);
        settle();
        chk("t4_tick", 32'(tick), 1);
        chk("t4_rem4", 32'(remaining), 4);
        cyc(1'b1, 1'b0, 16'd0);
        settle();
        chk("t4_abort_busy", 32'(busy), 0);
        chk("t4_abort_rem", 32'(remaining), 0);
        chk("t4_no_exp", n_exp - base_e, 0);

        // 5: zero load while idle is ignored
        cyc(1'b1, 1'b1, 16'd0);
        settle();
        chk("t5_busy", 32'(busy), 0);
        chk("t5_rem", 32'(remaining), 0);

        // maximum load value, then abort
        cyc(1'b1, 1'b0, 16'hFFFF);
        settle();
        chk("max_rem", 32'(remaining), 65535);
        cyc(1'b1, 1'b0, 16'd0);

        // 6: reset in the middle of a periodic run
        cyc(1'b1, 1'b1, 16'd7);
        settle();
        chk("t6_rem7", 32'(remaining), 7);
        dcnt = dcnt + 8'd1;
        step(1'b1, dcnt[7], 1'b0, 1'b0, '0);
        settle();
        chk("t6_busy", 32'(busy), 0);
        chk("t6_rem", 32'(remaining), 0);
        chk("t6_exp", 32'(expire), 0);
        base_e = n_exp;
        run(1024);
        settle();
        chk("t6_no_exp", n_exp - base_e, 0);

        for (int i = 0; i < 4 && sb.size() > 0; i++) @(posedge clk_in);
        #2;
        chk("sb_drained", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
